// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the program-counter / branch controller.
//
// Contents:
//   state_e         : controller FSM state encoding (RUN, RESOLVE, HALT)
//   PC_W_DEFAULT    : default program-counter width (must match table target width)
//   IDX_W           : jump-target table index width
//   START_DEFAULT   : default PC value loaded on reset
package pc_pkg;

    localparam int PC_W_DEFAULT  = 10;
    localparam int IDX_W         = 4;
    localparam int START_DEFAULT = 0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

endpackage

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl -- program counter with table-driven branch resolution.
//
// The PC normally increments every unstalled cycle. A taken branch (br_req &
// br_cond) registers its table index onto lut_addr and spends one bubble cycle
// in RESOLVE; on the following unstalled edge the PC is loaded from the
// external jump-target table (lut_target) and br_taken pulses for one cycle
// alongside the new PC. halt_req parks the controller in HALT until Reset.
//
// Configuration macro: PC_RELATIVE_BRANCH_EN
//   defined   : br_rel selects absolute target (0) or signed D-bit offset (1)
//   undefined : br_rel is ignored, every taken branch is absolute
//
// Ports:
//   Clk        in   sole clock, rising edge
//   Reset      in   asynchronous, active-high
//   stall      in   freeze PC, state and lut_addr
//   br_req     in   instruction at pc is a branch
//   br_cond    in   branch condition; taken when br_req & br_cond
//   br_idx     in   [IDX_W-1:0] table index carried by the branch
//   br_rel     in   1 = table entry is a relative offset
//   halt_req   in   stop fetching (priority over a branch)
//   lut_addr   out  [IDX_W-1:0] registered table index
//   lut_target in   [D-1:0] combinational table response for lut_addr
//   pc         out  [D-1:0] current program counter
//   br_taken   out  one-cycle pulse together with the table-loaded pc
//   halted     out  high while in HALT
//   dbg_state  out  [1:0] FSM state for observation
//
// Handshake: there is no valid/ready pair; stall is a level-sensitive hold
// that, when high on a rising edge, leaves every register unchanged except
// br_taken, which always returns low.
module pc_branch_ctrl
    import pc_pkg::*;
#(
    parameter int D     = PC_W_DEFAULT,
    parameter int START = START_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             stall,
    input  logic             br_req,
    input  logic             br_cond,
    input  logic [IDX_W-1:0] br_idx,
    input  logic             br_rel,
    input  logic             halt_req,
    output logic [IDX_W-1:0] lut_addr,
    input  logic [D-1:0]     lut_target,
    output logic [D-1:0]     pc,
    output logic             br_taken,
    output logic             halted,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [IDX_W-1:0] lut_addr_q, lut_addr_d;
    logic             br_taken_q, br_taken_d;
    logic [D-1:0]     target_pc;

`ifdef PC_RELATIVE_BRANCH_EN
    logic br_rel_q, br_rel_d;

    // Unsigned D-bit add is identical to adding a two's-complement offset mod 2^D.
    assign target_pc = br_rel_q ? (pc_q + lut_target) : lut_target;
`else
    logic unused_br_rel;

    assign unused_br_rel = br_rel;
    assign target_pc     = lut_target;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        lut_addr_d = lut_addr_q;
        br_taken_d = 1'b0;
`ifdef PC_RELATIVE_BRANCH_EN
        br_rel_d   = br_rel_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (br_req && br_cond) begin
                        state_d    = ST_RESOLVE;
                        lut_addr_d = br_idx;
`ifdef PC_RELATIVE_BRANCH_EN
                        br_rel_d   = br_rel;
`endif
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            ST_RESOLVE: begin
                if (!stall) begin
                    pc_d       = target_pc;
                    br_taken_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_HALT: begin
                // Frozen until Reset.
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_RUN;
            pc_q       <= D'(START);
            lut_addr_q <= '0;
            br_taken_q <= 1'b0;
`ifdef PC_RELATIVE_BRANCH_EN
            br_rel_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lut_addr_q <= lut_addr_d;
            br_taken_q <= br_taken_d;
`ifdef PC_RELATIVE_BRANCH_EN
            br_rel_q   <= br_rel_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign lut_addr  = lut_addr_q;
    assign br_taken  = br_taken_q;
    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
module tb_pc_branch_ctrl;
    import pc_pkg::*;

    localparam int D     = PC_W_DEFAULT;
    localparam int START = START_DEFAULT;
    localparam int MODN  = 1 << D;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic             Reset;
    logic             stall, br_req, br_cond, br_rel, halt_req;
    logic [IDX_W-1:0] br_idx;
    logic [IDX_W-1:0] lut_addr;
    logic [D-1:0]     lut_target;
    logic [D-1:0]     pc;
    logic             br_taken, halted;
    logic [1:0]       dbg_state;

    // external jump-target table
    logic [D-1:0] tbl [16];
    assign lut_target = tbl[lut_addr];

    pc_branch_ctrl #(.D(D), .START(START)) dut (
        .Clk(Clk), .Reset(Reset), .stall(stall), .br_req(br_req),
        .br_cond(br_cond), .br_idx(br_idx), .br_rel(br_rel),
        .halt_req(halt_req), .lut_addr(lut_addr), .lut_target(lut_target),
        .pc(pc), .br_taken(br_taken), .halted(halted), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    // mode: 0 fetching, 1 waiting for table target, 2 stopped
    int m_pc;
    int m_mode;
    int m_addr;
    bit m_rel;
    bit m_taken;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_pc = START; m_mode = 0; m_addr = 0; m_rel = 0; m_taken = 0;
    endtask

    // Apply one rising edge to the model using the current inputs.
    task automatic model_edge();
        m_taken = 0;
        if (m_mode == 0) begin
            if (!stall) begin
                if (halt_req) m_mode = 2;
                else if (br_req && br_cond) begin
                    m_mode = 1;
                    m_addr = int'(br_idx);
`ifdef PC_RELATIVE_BRANCH_EN
                    m_rel  = br_rel;
`else
                    m_rel  = 0;
`endif
                end else m_pc = (m_pc + 1) % MODN;
            end
        end else if (m_mode == 1) begin
            if (!stall) begin
                if (m_rel) m_pc = (m_pc + int'(tbl[m_addr])) % MODN;
                else       m_pc = int'(tbl[m_addr]);
                m_taken = 1;
                m_mode  = 0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pc",       32'(pc),       32'(m_pc));
        chk("lut_addr", 32'(lut_addr), 32'(m_addr));
        chk("br_taken", 32'(br_taken), 32'(m_taken));
        chk("halted",   32'(halted),   32'(m_mode == 2));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic rq, input logic c,
                         input int idx, input logic rel, input logic h);
        stall = s; br_req = rq; br_cond = c; br_idx = 4'(idx); br_rel = rel; halt_req = h;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge Clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        model_reset();
        check_model();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check_model();
    endtask

    // load pc with an absolute target via table slot idx
    task automatic jump_abs(input int idx, input int target);
        tbl[idx] = D'(target);
        drive(1'b0, 1'b1, 1'b1, idx, 1'b0, 1'b0);
        cycle();
        idle();
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        Reset = 1'b0;
        idle();
        #1;

        // reset state
        do_reset();
        chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
        chk("rst_pc", 32'(pc), 32'(START));

        // free running count
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("count_pc", 32'(pc), 32'(i));
            chk("count_taken", 32'(br_taken), 32'd0);
        end

        // absolute branch, two-cycle latency
        tbl[2] = D'(41);
        drive(1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        cycle();
        chk("abs_bubble_pc", 32'(pc), 32'd4);
        chk("abs_bubble_addr", 32'(lut_addr), 32'd2);
        chk("abs_bubble_taken", 32'(br_taken), 32'd0);
        idle();
        cycle();
        chk("abs_pc", 32'(pc), 32'd41);
        chk("abs_taken", 32'(br_taken), 32'd1);
        cycle();
        chk("abs_after_pc", 32'(pc), 32'd42);
        chk("abs_after_taken", 32'(br_taken), 32'd0);

        // stall in RUN holds
        drive(1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b1);
        cycle();
        cycle();
        chk("run_stall_pc", 32'(pc), 32'd42);
        chk("run_stall_state", 32'(dbg_state), 32'(ST_RUN));

        // not-taken branch
        jump_abs(0, 7);
        chk("nt_setup_pc", 32'(pc), 32'd7);
        drive(1'b0, 1'b1, 1'b0, 9, 1'b0, 1'b0);
        cycle();
        chk("nt_pc", 32'(pc), 32'd8);
        chk("nt_state", 32'(dbg_state), 32'(ST_RUN));
        chk("nt_taken", 32'(br_taken), 32'd0);

        // relative branches (ignored when the feature is compiled out)
        jump_abs(4, 20);
        tbl[3] = D'(1023);
        drive(1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        cycle();
        idle();
        cycle();
`ifdef PC_RELATIVE_BRANCH_EN
        chk("rel_neg_pc", 32'(pc), 32'd19);
`else
        chk("rel_neg_pc", 32'(pc), 32'd1023);
`endif
        jump_abs(5, 1020);
        tbl[6] = D'(20);
        drive(1'b0, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        cycle();
        idle();
        cycle();
`ifdef PC_RELATIVE_BRANCH_EN
        chk("rel_wrap_pc", 32'(pc), 32'd16);
`else
        chk("rel_wrap_pc", 32'(pc), 32'd20);
`endif

        // increment wrap 1023 -> 0
        jump_abs(8, 1023);
        cycle();
        chk("inc_wrap_pc", 32'(pc), 32'd0);

        // stall while resolving
        tbl[1] = D'(11);
        drive(1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 9, 1'b1, 1'b1);
            cycle();
            chk("res_stall_addr", 32'(lut_addr), 32'd1);
            chk("res_stall_taken", 32'(br_taken), 32'd0);
        end
        idle();
        cycle();
        chk("res_stall_pc", 32'(pc), 32'd11);
        chk("res_stall_taken1", 32'(br_taken), 32'd1);
        cycle();
        chk("res_stall_taken2", 32'(br_taken), 32'd0);

        // halt has priority over a taken branch; halt is sticky
        jump_abs(7, 9);
        drive(1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1);
        cycle();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd9);
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b1, $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
        end
        chk("halt_hold_pc", 32'(pc), 32'd9);

        // reset exits halt
        do_reset();
        chk("halt_exit", 32'(halted), 32'd0);

        // reset mid-RESOLVE aborts the branch immediately
        drive(1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        cycle();
        idle();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk("abort_pc", 32'(pc), 32'(START));
        chk("abort_state", 32'(dbg_state), 32'(ST_RUN));
        chk("abort_addr", 32'(lut_addr), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cycle();
        chk("abort_no_load_pc", 32'(pc), 32'(START + 1));
        chk("abort_no_taken", 32'(br_taken), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 16; i++) tbl[i] = D'($urandom_range(0, MODN - 1));
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 15),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
                if ($urandom_range(0, 9) == 0)
                    tbl[$urandom_range(0, 15)] = D'($urandom_range(0, MODN - 1));
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
